// File: rtl/sync_debounce_edge.sv
// rtl/sync_debounce_edge.sv - stable-count debounce filter with edge pulses, sticky flags and edge counter
// Optional glitch counter output enabled by defining SYNC_DEBOUNCE_GLITCH_CNT_EN.
module sync_debounce_edge #(
    parameter int DB_CYCLES = 4,
    parameter int CNT_W     = 8
) (
    input  logic             CLOCK,
    input  logic             RESETN,
    input  logic             sync_in,
    input  logic             db_en,
    input  logic             clr_status,
    output logic             level_out,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic             rise_sticky,
    output logic             fall_sticky,
    output logic [CNT_W-1:0] edge_cnt
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    ,
    output logic [CNT_W-1:0] glitch_cnt
`endif
);

    typedef enum logic [1:0] {ST_LO, CHK_HI, ST_HI, CHK_LO} state_t;

    localparam logic [7:0] DB_LAST = 8'(DB_CYCLES - 1);

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             rise_sticky_q, rise_sticky_d;
    logic             fall_sticky_q, fall_sticky_d;
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic             edge_event;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        if (!db_en) begin
            // Bypass: follow the input directly and park in the matching stable state.
            level_d = sync_in;
            cnt_d   = 8'd0;
            state_d = sync_in ? ST_HI : ST_LO;
        end else begin
            case (state_q)
                ST_LO: begin
                    if (sync_in) begin
                        if (DB_CYCLES == 1) begin
                            state_d = ST_HI;
                            level_d = 1'b1;
                        end else begin
                            state_d = CHK_HI;
                            cnt_d   = 8'd1;
                        end
                    end
                end
                CHK_HI: begin
                    if (!sync_in) begin
                        state_d = ST_LO;
                        cnt_d   = 8'd0;
                    end else if (cnt_q == DB_LAST) begin
                        state_d = ST_HI;
                        level_d = 1'b1;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                ST_HI: begin
                    if (!sync_in) begin
                        if (DB_CYCLES == 1) begin
                            state_d = ST_LO;
                            level_d = 1'b0;
                        end else begin
                            state_d = CHK_LO;
                            cnt_d   = 8'd1;
                        end
                    end
                end
                CHK_LO: begin
                    if (sync_in) begin
                        state_d = ST_HI;
                        cnt_d   = 8'd0;
                    end else if (cnt_q == DB_LAST) begin
                        state_d = ST_LO;
                        level_d = 1'b0;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_d = ST_LO;
                    cnt_d   = 8'd0;
                end
            endcase
        end
    end

    // Pulses and status derive from level transitions, so bypass and debounce share them.
    always_comb begin
        rise_d        = level_d & ~level_q;
        fall_d        = ~level_d & level_q;
        edge_event    = rise_d | fall_d;
        rise_sticky_d = rise_d | (rise_sticky_q & ~clr_status);
        fall_sticky_d = fall_d | (fall_sticky_q & ~clr_status);
        if (clr_status) begin
            edge_cnt_d = CNT_W'(edge_event);
        end else begin
            edge_cnt_d = edge_cnt_q + CNT_W'(edge_event);
        end
    end

    always_ff @(posedge CLOCK) begin
        if (!RESETN) begin
            state_q       <= ST_LO;
            cnt_q         <= 8'd0;
            level_q       <= 1'b0;
            rise_q        <= 1'b0;
            fall_q        <= 1'b0;
            rise_sticky_q <= 1'b0;
            fall_sticky_q <= 1'b0;
            edge_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            level_q       <= level_d;
            rise_q        <= rise_d;
            fall_q        <= fall_d;
            rise_sticky_q <= rise_sticky_d;
            fall_sticky_q <= fall_sticky_d;
            edge_cnt_q    <= edge_cnt_d;
        end
    end

    assign level_out   = level_q;
    assign rise_pulse  = rise_q;
    assign fall_pulse  = fall_q;
    assign rise_sticky = rise_sticky_q;
    assign fall_sticky = fall_sticky_q;
    assign edge_cnt    = edge_cnt_q;

`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    logic             glitch;
    logic [CNT_W-1:0] glitch_cnt_q, glitch_cnt_d;

    // A check abandoned by dropping db_en is not a glitch.
    always_comb begin
        glitch = db_en & (((state_q == CHK_HI) & ~sync_in) | ((state_q == CHK_LO) & sync_in));
        if (clr_status) begin
            glitch_cnt_d = CNT_W'(glitch);
        end else if (glitch && !(&glitch_cnt_q)) begin
            glitch_cnt_d = glitch_cnt_q + CNT_W'(1);
        end else begin
            glitch_cnt_d = glitch_cnt_q;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (!RESETN) begin
            glitch_cnt_q <= '0;
        end else begin
            glitch_cnt_q <= glitch_cnt_d;
        end
    end

    assign glitch_cnt = glitch_cnt_q;
`endif

endmodule

// File: tb/tb_sync_debounce_edge.sv
// tb/tb_sync_debounce_edge.sv - randomized and directed bench for sync_debounce_edge against a run-length model
module tb_sync_debounce_edge;

    typedef struct {
        bit level;
        int run;
        bit rise;
        bit fall;
        bit rs;
        bit fs;
        int ecnt;
        int gcnt;
    } model_t;

    logic CLOCK = 1'b0;
    logic RESETN = 1'b0;
    logic sync_in = 1'b0;
    logic db_en = 1'b1;
    logic clr_status = 1'b0;

    logic       a_level, a_rise, a_fall, a_rs, a_fs;
    logic [7:0] a_cnt;
    logic       b_level, b_rise, b_fall, b_rs, b_fs;
    logic [2:0] b_cnt;
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] a_gl;
    logic [2:0] b_gl;
`endif

    logic [12:0] a_obs;
    logic [7:0]  b_obs;
    assign a_obs = {a_level, a_rise, a_fall, a_rs, a_fs, a_cnt};
    assign b_obs = {b_level, b_rise, b_fall, b_rs, b_fs, b_cnt};

    int vectors = 0;
    int errors = 0;
    model_t ma, mb;

    always #5 CLOCK = ~CLOCK;

    sync_debounce_edge #(.DB_CYCLES(4), .CNT_W(8)) dut (
        .CLOCK(CLOCK), .RESETN(RESETN), .sync_in(sync_in), .db_en(db_en), .clr_status(clr_status),
        .level_out(a_level), .rise_pulse(a_rise), .fall_pulse(a_fall),
        .rise_sticky(a_rs), .fall_sticky(a_fs), .edge_cnt(a_cnt)
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
        , .glitch_cnt(a_gl)
`endif
    );

    sync_debounce_edge #(.DB_CYCLES(1), .CNT_W(3)) dut_w3 (
        .CLOCK(CLOCK), .RESETN(RESETN), .sync_in(sync_in), .db_en(db_en), .clr_status(clr_status),
        .level_out(b_level), .rise_pulse(b_rise), .fall_pulse(b_fall),
        .rise_sticky(b_rs), .fall_sticky(b_fs), .edge_cnt(b_cnt)
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
        , .glitch_cnt(b_gl)
`endif
    );

    // Level flips once the input has disagreed with it for dbc consecutive samples.
    function automatic model_t mstep(model_t m, bit rst_n, bit s, bit en, bit clr, int dbc, int w);
        model_t n;
        bit ev;
        bit gl;
        n = m;
        ev = 0;
        gl = 0;
        n.rise = 0;
        n.fall = 0;
        if (!rst_n) begin
            n = '{default: 0};
            return n;
        end
        if (!en) begin
            if (s != m.level) ev = 1;
            n.level = s;
            n.run = 0;
        end else if (s != m.level) begin
            n.run = m.run + 1;
            if (n.run >= dbc) begin
                n.level = s;
                n.run = 0;
                ev = 1;
            end
        end else begin
            gl = (m.run > 0);
            n.run = 0;
        end
        if (ev) begin
            n.rise = n.level;
            n.fall = !n.level;
        end
        n.rs = n.rise | (m.rs & !clr);
        n.fs = n.fall | (m.fs & !clr);
        n.ecnt = clr ? int'(ev) : (m.ecnt + int'(ev)) % (1 << w);
        if (clr) n.gcnt = int'(gl);
        else if (gl && m.gcnt != (1 << w) - 1) n.gcnt = m.gcnt + 1;
        return n;
    endfunction

    task automatic drive(input bit rst, input bit s, input bit en, input bit clr);
        RESETN = rst;
        sync_in = s;
        db_en = en;
        clr_status = clr;
        @(posedge CLOCK);
        ma = mstep(ma, rst, s, en, clr, 4, 8);
        mb = mstep(mb, rst, s, en, clr, 1, 3);
        #1;
    endtask

    task automatic test_reset();
        drive(0, 1, 0, 0);
        vectors++;
        if (a_obs !== 13'd0) begin
            errors++;
            $display("FAIL reset_a: got %h want 0", a_obs);
        end
        vectors++;
        if (b_obs !== 8'd0) begin
            errors++;
            $display("FAIL reset_b: got %h want 0", b_obs);
        end
    endtask

    task automatic test_rise_latency();
        drive(0, 0, 1, 0);
        for (int i = 0; i < 6; i++) begin
            drive(1, 1, 1, 0);
            vectors++;
            if (a_level !== (i >= 3) || a_rise !== (i == 3) || a_fall !== 1'b0) begin
                errors++;
                $display("FAIL rise_latency edge %0d: level=%b rise=%b fall=%b want level=%b rise=%b",
                         i, a_level, a_rise, a_fall, i >= 3, i == 3);
            end
            vectors++;
            if (b_level !== 1'b1 || b_rise !== (i == 0)) begin
                errors++;
                $display("FAIL rise_db1 edge %0d: level=%b rise=%b want 1 %b", i, b_level, b_rise, i == 0);
            end
        end
        vectors++;
        if (a_rs !== 1'b1 || a_fs !== 1'b0 || a_cnt !== 8'd1) begin
            errors++;
            $display("FAIL rise_status: rs=%b fs=%b cnt=%0d want 1 0 1", a_rs, a_fs, a_cnt);
        end
    endtask

    task automatic test_glitch();
        drive(0, 0, 1, 0);
        for (int i = 0; i < 8; i++) begin
            drive(1, i < 3, 1, 0);
            vectors++;
            if (a_level !== 1'b0 || a_rise !== 1'b0 || a_cnt !== 8'd0) begin
                errors++;
                $display("FAIL glitch edge %0d: level=%b rise=%b cnt=%0d want 0 0 0", i, a_level, a_rise, a_cnt);
            end
        end
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
        vectors++;
        if (a_gl !== 8'd1) begin
            errors++;
            $display("FAIL glitch_cnt: got %0d want 1", a_gl);
        end
`endif
    endtask

    task automatic test_full_cycle();
        drive(0, 0, 1, 0);
        for (int i = 0; i < 4; i++) drive(1, 1, 1, 0);
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 1, 0);
            vectors++;
            if (a_fall !== (i == 3) || a_level !== (i < 3) || a_rise !== 1'b0) begin
                errors++;
                $display("FAIL full_cycle edge %0d: level=%b fall=%b rise=%b want level=%b fall=%b",
                         i, a_level, a_fall, a_rise, i < 3, i == 3);
            end
        end
        vectors++;
        if (a_cnt !== 8'd2 || a_rs !== 1'b1 || a_fs !== 1'b1) begin
            errors++;
            $display("FAIL full_status: cnt=%0d rs=%b fs=%b want 2 1 1", a_cnt, a_rs, a_fs);
        end
    endtask

    task automatic test_clr_on_fall();
        drive(0, 0, 1, 0);
        for (int i = 0; i < 4; i++) drive(1, 1, 1, 0);
        for (int i = 0; i < 3; i++) drive(1, 0, 1, 0);
        drive(1, 0, 1, 1);
        vectors++;
        if (a_fall !== 1'b1 || a_fs !== 1'b1 || a_rs !== 1'b0 || a_cnt !== 8'd1) begin
            errors++;
            $display("FAIL clr_on_fall: fall=%b fs=%b rs=%b cnt=%0d want 1 1 0 1", a_fall, a_fs, a_rs, a_cnt);
        end
        drive(1, 0, 1, 0);
        vectors++;
        if (a_fall !== 1'b0 || a_fs !== 1'b1 || a_cnt !== 8'd1) begin
            errors++;
            $display("FAIL clr_after: fall=%b fs=%b cnt=%0d want 0 1 1", a_fall, a_fs, a_cnt);
        end
    endtask

    task automatic test_bypass();
        bit s;
        int pulses;
        bit saw_wrap;
        logic [2:0] prev_b;
        s = 0;
        pulses = 0;
        saw_wrap = 0;
        drive(0, 0, 0, 0);
        prev_b = b_cnt;
        for (int i = 0; i < 10; i++) begin
            s = !s;
            drive(1, s, 0, 0);
            vectors++;
            if (a_level !== s || (a_rise | a_fall) !== 1'b1) begin
                errors++;
                $display("FAIL bypass edge %0d: level=%b rise=%b fall=%b want level=%b pulse", i, a_level, a_rise, a_fall, s);
            end
            if (a_rise | a_fall) pulses++;
            if (prev_b == 3'd7 && b_cnt == 3'd0) saw_wrap = 1;
            prev_b = b_cnt;
        end
        vectors++;
        if (pulses != 10 || a_cnt !== 8'd10) begin
            errors++;
            $display("FAIL bypass_count: pulses=%0d cnt=%0d want 10 10", pulses, a_cnt);
        end
        vectors++;
        if (!saw_wrap || b_cnt !== 3'd2) begin
            errors++;
            $display("FAIL bypass_wrap: wrap_seen=%b cnt=%0d want 1 2", saw_wrap, b_cnt);
        end
    endtask

    task automatic test_reset_mid_check();
        drive(0, 0, 1, 0);
        drive(1, 1, 1, 0);
        drive(1, 1, 1, 0);
        drive(0, 1, 1, 0);
        vectors++;
        if (a_obs !== 13'd0) begin
            errors++;
            $display("FAIL reset_mid: got %h want 0", a_obs);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 1, 0);
            vectors++;
            if (a_level !== (i == 3) || a_rise !== (i == 3)) begin
                errors++;
                $display("FAIL reset_mid_relatch edge %0d: level=%b rise=%b want %b", i, a_level, a_rise, i == 3);
            end
        end
    endtask

    task automatic test_random();
        bit s;
        bit en;
        bit rst;
        bit clr;
        s = 0;
        en = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) s = !s;
            if ($urandom_range(0, 24) == 0) en = !en;
            clr = ($urandom_range(0, 9) == 0);
            rst = ($urandom_range(0, 299) != 0);
            drive(rst, s, en, clr);
            vectors++;
            if (a_obs !== {ma.level, ma.rise, ma.fall, ma.rs, ma.fs, 8'(ma.ecnt)}) begin
                errors++;
                $display("FAIL random_a cycle %0d: got %h want %h", i, a_obs,
                         {ma.level, ma.rise, ma.fall, ma.rs, ma.fs, 8'(ma.ecnt)});
            end
            vectors++;
            if (b_obs !== {mb.level, mb.rise, mb.fall, mb.rs, mb.fs, 3'(mb.ecnt)}) begin
                errors++;
                $display("FAIL random_b cycle %0d: got %h want %h", i, b_obs,
                         {mb.level, mb.rise, mb.fall, mb.rs, mb.fs, 3'(mb.ecnt)});
            end
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
            vectors++;
            if (a_gl !== 8'(ma.gcnt) || b_gl !== 3'(mb.gcnt)) begin
                errors++;
                $display("FAIL random_glitch cycle %0d: got %0d %0d want %0d %0d", i, a_gl, b_gl, ma.gcnt, mb.gcnt);
            end
`endif
        end
    endtask

    initial begin
        ma = '{default: 0};
        mb = '{default: 0};
        #2;
        test_reset();
        test_rise_latency();
        test_glitch();
        test_full_cycle();
        test_clr_on_fall();
        test_bypass();
        test_reset_mid_check();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
